// File: rtl/sevenseg_scan_ctrl.sv
// Purpose: time-multiplexed seven-segment scan controller with double-buffered digit storage (optional macro SEVENSEG_LZ_BLANK_EN adds leading-zero suppression).
// Latency: all outputs are registered from next state; host loads become visible at the next frame boundary (at most one frame).
// Backpressure: none; load is always accepted and the last load before a frame boundary wins.
module sevenseg_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100000,
  parameter int GHOST_CYC  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_en,
  input  logic [NUM_DIGITS-1:0]   blank_en,
  output logic [6:0]              data,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_start
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             cnt_wrap;
  logic             commit;
  int               cnt_nxt_int;
  logic             ghost;

  logic [4*NUM_DIGITS-1:0] pend_val, act_val, act_val_nxt;
  logic [NUM_DIGITS-1:0]   pend_dp, act_dp, act_dp_nxt;
  logic [NUM_DIGITS-1:0]   pend_blank, act_blank, act_blank_nxt;
  logic                    pend_vld, pend_vld_nxt;

  logic [NUM_DIGITS-1:0]   lz;
  logic [6:0]              data_nxt;
  logic [NUM_DIGITS-1:0]   an_n_nxt;
  logic                    frame_start_nxt;

  // Slot counter and digit index advance; commit happens when the last slot of a frame ends.
  always_comb begin
    cnt_wrap = (cnt == CNT_LAST);
    cnt_nxt  = cnt_wrap ? '0 : cnt + 1'b1;
    idx_nxt  = idx;
    if (cnt_wrap) begin
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
    commit      = cnt_wrap && (idx == IDX_LAST);
    cnt_nxt_int = int'(cnt_nxt);
    ghost       = (cnt_nxt_int < GHOST_CYC);
  end

  // Next active/pending buffer contents; a load on the commit edge bypasses pending.
  always_comb begin
    act_val_nxt   = act_val;
    act_dp_nxt    = act_dp;
    act_blank_nxt = act_blank;
    pend_vld_nxt  = pend_vld;
    if (commit) begin
      if (load) begin
        act_val_nxt   = value;
        act_dp_nxt    = dp_en;
        act_blank_nxt = blank_en;
      end else if (pend_vld) begin
        act_val_nxt   = pend_val;
        act_dp_nxt    = pend_dp;
        act_blank_nxt = pend_blank;
      end
      pend_vld_nxt = 1'b0;
    end else if (load) begin
      pend_vld_nxt = 1'b1;
    end
  end

  // Leading-zero mask over the next active buffer; digit 0 is never suppressed.
  always_comb begin
    lz = '0;
`ifdef SEVENSEG_LZ_BLANK_EN
    begin
      logic lz_run;
      lz_run = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
        if (lz_run && (act_val_nxt[4*i +: 4] == 4'h0) && !act_dp_nxt[i]) begin
          lz[i] = 1'b1;
        end else begin
          lz_run = 1'b0;
        end
      end
    end
`endif
  end

  // Output words for the digit selected in the next cycle.
  always_comb begin
    data_nxt = 7'b100_0000;
    an_n_nxt = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_nxt == IDX_W'(i)) begin
        data_nxt = {act_blank_nxt[i] | lz[i], 1'b0, act_dp_nxt[i], act_val_nxt[4*i +: 4]};
        if (!ghost) begin
          an_n_nxt[i] = 1'b0;
        end
      end
    end
    frame_start_nxt = (idx_nxt == '0) && (cnt_nxt == '0);
  end

  // Scan state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      idx         <= '0;
      data        <= 7'b100_0000;
      an_n        <= '1;
      frame_start <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      data        <= data_nxt;
      an_n        <= an_n_nxt;
      frame_start <= frame_start_nxt;
    end
  end

  // Pending and active digit buffers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_vld   <= 1'b0;
      act_val    <= '0;
      act_dp     <= '0;
      act_blank  <= '0;
    end else begin
      if (load && !commit) begin
        pend_val   <= value;
        pend_dp    <= dp_en;
        pend_blank <= blank_en;
      end
      pend_vld  <= pend_vld_nxt;
      act_val   <= act_val_nxt;
      act_dp    <= act_dp_nxt;
      act_blank <= act_blank_nxt;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Purpose: self-checking bench for sevenseg_scan_ctrl against a time-indexed reference model.
// Latency: model predicts outputs from the cycle number since reset release.
// Backpressure: not applicable; loads are driven freely.
module tb_sevenseg_scan_ctrl;

  localparam int N     = 4;
  localparam int SD    = 4;
  localparam int GH    = 1;
  localparam int FRAME = N * SD;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   value = '0;
  logic [3:0]    dp_en = '0;
  logic [3:0]    blank_en = '0;
  logic [6:0]    data;
  logic [3:0]    an_n;
  logic          frame_start;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int          k;
  logic [15:0] m_act_v, m_pend_v;
  logic [3:0]  m_act_dp, m_pend_dp, m_act_bl, m_pend_bl;
  bit          m_pv;

  sevenseg_scan_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(SD), .GHOST_CYC(GH)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_en(dp_en),
    .blank_en(blank_en), .data(data), .an_n(an_n), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    k = 0; m_pv = 0;
    m_act_v = '0; m_act_dp = '0; m_act_bl = '0;
    m_pend_v = '0; m_pend_dp = '0; m_pend_bl = '0;
  endtask

  function automatic logic [3:0] lz_mask();
    logic [3:0] m;
    bit run;
    m = '0;
`ifdef SEVENSEG_LZ_BLANK_EN
    run = 1;
    for (int d = N - 1; d >= 1; d--) begin
      if (run && m_act_v[4*d +: 4] == 4'h0 && !m_act_dp[d]) m[d] = 1'b1;
      else run = 0;
    end
`else
    run = 0;
`endif
    return m;
  endfunction

  function automatic logic [6:0] exp_data();
    int d;
    logic [3:0] lzm;
    d = (k / SD) % N;
    lzm = lz_mask();
    return {m_act_bl[d] | lzm[d], 1'b0, m_act_dp[d], m_act_v[4*d +: 4]};
  endfunction

  task automatic check_outputs();
    int d;
    logic [3:0] e_an;
    d = (k / SD) % N;
    e_an = ((k % SD) < GH) ? 4'hF : ~(4'b0001 << d);
    chk("an_n", 32'(an_n), 32'(e_an));
    chk("frame_start", 32'(frame_start), 32'((k % FRAME) == 0));
    chk("data", 32'(data), 32'(exp_data()));
  endtask

  task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
    load = ld; value = v; dp_en = dp; blank_en = bl;
    @(posedge clk);
    k++;
    if ((k % FRAME) == 0) begin
      if (ld) begin
        m_act_v = v; m_act_dp = dp; m_act_bl = bl;
      end else if (m_pv) begin
        m_act_v = m_pend_v; m_act_dp = m_pend_dp; m_act_bl = m_pend_bl;
      end
      m_pv = 0;
    end else if (ld) begin
      m_pend_v = v; m_pend_dp = dp; m_pend_bl = bl; m_pv = 1;
    end
    #1;
    load = 1'b0;
    check_outputs();
  endtask

  task automatic run_to(input int target);
    while (k < target) step(1'b0, value, dp_en, blank_en);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_an_n", 32'(an_n), 32'h0000_000F);
    chk("rst_data", 32'(data), 32'h0000_0040);
    chk("rst_frame_start", 32'(frame_start), 32'h0);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    do_reset();

    // 1: free-running scan with empty buffers
    run_to(20);

    // 2: mid-frame load, visible from the next frame
    run_to(21);
    step(1'b1, 16'hFCA3, 4'b0100, 4'b0000);
    run_to(33); chk("t2_d0", 32'(data), 32'h03);
    run_to(37); chk("t2_d1", 32'(data), 32'h0A);
    run_to(41); chk("t2_d2", 32'(data), 32'h1C);
    run_to(45); chk("t2_d3", 32'(data), 32'h0F);

    // 3: two loads in one frame, last wins
    run_to(50);
    step(1'b1, 16'h1111, 4'b0000, 4'b0000);
    run_to(55);
    step(1'b1, 16'h2222, 4'b0000, 4'b0000);
    run_to(65); chk("t3_d0", 32'(data), 32'h02);
    run_to(73); chk("t3_d2", 32'(data), 32'h02);
    run_to(80);

    // 4: load on the commit edge goes straight to active
    run_to(95);
    step(1'b1, 16'h4567, 4'b0000, 4'b0000);
    chk("t4_commit_d0", 32'(data), 32'h07);
    chk("t4_frame_start", 32'(frame_start), 32'h1);
    run_to(100);

    // 5: forced blank on digit 3, anode still strobes
    step(1'b1, 16'h8888, 4'b0000, 4'b1000);
    run_to(125);
    chk("t5_d3_data", 32'(data), 32'h48);
    chk("t5_d3_an", 32'(an_n), 32'h7);

    // random loads checked against the model every cycle
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0)
        step(1'b1, 16'($urandom), 4'($urandom), 4'($urandom));
      else
        step(1'b0, value, dp_en, blank_en);
    end

    // 6: leading-zero case
    step(1'b1, 16'h0050, 4'b0000, 4'b0000);
    run_to(((k / FRAME) + 1) * FRAME);
    run_to(k + 1);
    chk("t6_d0", 32'(data), 32'h00);
    run_to(k + 4);
    chk("t6_d1", 32'(data), 32'h05);
    run_to(k + 4);
`ifdef SEVENSEG_LZ_BLANK_EN
    chk("t6_d2", 32'(data), 32'h40);
`else
    chk("t6_d2", 32'(data), 32'h00);
`endif
    run_to(k + 4);
`ifdef SEVENSEG_LZ_BLANK_EN
    chk("t6_d3", 32'(data), 32'h40);
`else
    chk("t6_d3", 32'(data), 32'h00);
`endif

    // reset asserted mid-slot while a digit is lit
    while ((k % SD) != 2) step(1'b0, value, dp_en, blank_en);
    chk("pre_rst_an_lit", 32'(an_n != 4'hF), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_an_n", 32'(an_n), 32'h0000_000F);
    chk("async_rst_data", 32'(data), 32'h0000_0040);
    chk("async_rst_fs", 32'(frame_start), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run_to(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_ctrl.md
Name: sevenseg_scan_ctrl

Overview:
- Time-multiplexed scan controller directly upstream of the seven_seg_n decoder.
- Holds NUM_DIGITS 4-bit hex nibbles plus per-digit decimal-point and blank flags.
- Cycles through the digits at a fixed slot rate, driving active-low anode enables and the 7-bit data word that seven_seg_n decodes.
- Double-buffers host updates so a frame never shows a mix of old and new values.

Parameters:
- NUM_DIGITS, default 8: digits scanned, range 2..8.
- SCAN_DIV, default 100000: clock cycles per digit slot, must be ≥ 4.
- GHOST_CYC, default 2: cycles at the start of each slot with all anodes off; 0 ≤ GHOST_CYC < SCAN_DIV.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  one-cycle strobe; captures value/dp_en/blank_en into the pending buffer.
- value  in  4*NUM_DIGITS  hex nibbles; digit i is value[4i+3:4i]; digit 0 is rightmost.
- dp_en  in  NUM_DIGITS  per-digit decimal point request.
- blank_en  in  NUM_DIGITS  per-digit forced blank.
- data  out  7  word to seven_seg_n:
  - bit6 = blank (highest priority)
  - bit5 = dash
  - bit4 = decimal point
  - bits3:0 = hex digit
- an_n  out  NUM_DIGITS  active-low anode enables; at most one bit low.
- frame_start  out  1  one-cycle pulse when digit 0's slot begins.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Ports are clk and rst_n.
- Reset values:
  - cnt = 0, idx = 0.
  - Pending and active buffers cleared to zero.
  - an_n = all ones.
  - data = 7'b100_0000 (blank).
  - frame_start = 0.
- Slot counter cnt:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - On wrap, idx advances by 1; NUM_DIGITS-1 wraps to 0.
  - Width of idx is $clog2(NUM_DIGITS).
- Outputs:
  - All outputs are registers computed from the next state, so they change on the same edge as cnt/idx.
  - There is no combinational path from any input to any output.
- an_n:
  - All ones while cnt < GHOST_CYC (ghost blanking).
  - Otherwise, bit idx = 0 and all other bits = 1.
- data for the current idx, taken from the active buffer:
  - bit6 = blank_en[idx]
  - bit5 = 0 (dash reserved, never driven by this block)
  - bit4 = dp_en[idx]
  - bits3:0 = value nibble idx
- frame_start:
  - High for exactly the one cycle where idx = 0 and cnt = 0.
  - Not asserted by reset itself; the first pulse comes after a full frame.
- Buffering:
  - load = 1 copies value/dp_en/blank_en into pending and sets the pending_valid flag.
  - Commit happens on the edge where idx wraps NUM_DIGITS-1→0 and cnt wraps: pending_valid moves pending into active and clears pending_valid.
  - If load coincides with that commit edge, the current input values commit directly to active and pending_valid ends cleared.
  - Multiple loads within one frame: the last one wins.
  - A load that arrives with no frame boundary pending waits, visible at most one frame later.
- Reset asserted mid-frame:
  - All state returns to reset values immediately; anodes go off asynchronously.
  - Scanning restarts at digit 0 after rst_n deasserts.
- NUM_DIGITS not a power of two: idx wraps explicitly at NUM_DIGITS-1 and never reaches unused codes.

Optional Feature:
- Macro: SEVENSEG_LZ_BLANK_EN.
- Defined: leading-zero suppression on the active buffer.
  - Scanning from digit NUM_DIGITS-1 downward, each digit whose nibble is 0 and dp_en is 0 gets data bit6 = 1.
  - Suppression stops at the first digit that is nonzero or has dp_en set.
  - Digit 0 is never suppressed.
  - blank_en still forces a blank independently.
- Undefined: no suppression; only blank_en blanks a digit.
- Suppression is computed from the active buffer only, so it changes only at frame boundaries.

Test Plan:
Bench parameters: NUM_DIGITS=4, SCAN_DIV=4, GHOST_CYC=1.
1. Reset then run 20 cycles:
   - an_n sequence per slot is 1111, then 1110 ×3, then 1101 ×3, and so on.
   - frame_start pulses once at cycle 16 after reset release.
   - With buffers at zero, data = 7'h00 in lit cycles.
2. load with value=16'hF_C_A_3, dp_en=4'b0100, blank_en=0 mid-frame:
   - Until the next frame, data stays at the old values.
   - After the next frame_start, data = 7'h03, 7'h0A, 7'h1C, 7'h0F for digits 0..3.
3. Two loads in one frame (value=16'h1111, then 16'h2222):
   - Next frame shows only 2s (data = 7'h02 on every digit).
4. load asserted on the commit edge:
   - Loaded values are visible in the frame starting at that edge.
5. blank_en = 4'b1000:
   - Digit 3 data = 7'b100_xxxx (bit6 = 1); an_n still strobes 0111.
6. SEVENSEG_LZ_BLANK_EN defined, value=16'h0050:
   - Digits 3 and 2 blanked (bit6 = 1); digit 1 = 7'h05; digit 0 = 7'h00.
   - Rerun with rst_n pulsed low mid-slot: an_n = 1111 within the same cycle.
